// File: rtl/run_controller_pkg.sv
// Shared state encoding for the run controller and the HEX display decoder.
package run_controller_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN     = 3'd0,
    ST_PAUSED  = 3'd1,
    ST_STEP    = 3'd2,
    ST_WAIT_IN = 3'd3,
    ST_PRINT   = 3'd4,
    ST_COMMIT  = 3'd5
  } run_state_t;

endpackage

// File: rtl/edge_sync.sv
// Multi-stage synchroniser for an asynchronous level; PULSE=1 turns the
// output into a one-cycle strobe on each synchronised rising edge.
module edge_sync #(
  parameter int STAGES = 2,
  parameter bit PULSE  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = PULSE ? (sync_q[STAGES-1] & ~prev_q) : sync_q[STAGES-1];

endmodule

// File: rtl/run_controller.sv
// Run/pause/step sequencer for the single-cycle datapath, with IN stalls
// waiting for the enter key and fixed-length PRINT holds.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int DATA_W            = 4,
  parameter int PRINT_HOLD_CYCLES = 4,
  parameter int SYNC_STAGES       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause_sw,
  input  logic              enter,
  input  logic              in_req,
  input  logic              print_req,
  input  logic [DATA_W-1:0] sw_value,
  output logic              cpu_en,
  output logic [31:0]       in_value,
  output logic              in_ack,
  output logic              print_active,
  output logic [2:0]        state
);

  localparam int CNT_W = (PRINT_HOLD_CYCLES > 1) ? $clog2(PRINT_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(PRINT_HOLD_CYCLES - 1);

  run_state_t       cur_state, next_state;
  logic [CNT_W-1:0] hold_cnt;
  logic [31:0]      in_value_q;
  logic             commit_is_in;
  logic             pause_s, enter_pulse;
  logic             cpu_en_c, load_cnt, dec_cnt, capture_in, commit_print;

  edge_sync #(.STAGES(SYNC_STAGES), .PULSE(1'b0)) u_pause_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pause_sw),
    .dout  (pause_s)
  );

  edge_sync #(.STAGES(SYNC_STAGES), .PULSE(1'b1)) u_enter_sync (
    .clk   (clk),
    .reset (reset),
    .din   (enter),
    .dout  (enter_pulse)
  );

  always_comb begin
    next_state   = cur_state;
    cpu_en_c     = 1'b0;
    load_cnt     = 1'b0;
    dec_cnt      = 1'b0;
    capture_in   = 1'b0;
    commit_print = 1'b0;
    case (cur_state)
      ST_RUN, ST_STEP: begin
        // Ordinary instructions commit here; IN/PRINT defer their commit.
        cpu_en_c = ~in_req & ~print_req;
        if (in_req) begin
          next_state = ST_WAIT_IN;
        end else if (print_req) begin
          next_state = ST_PRINT;
          load_cnt   = 1'b1;
        end else if (cur_state == ST_STEP) begin
          next_state = ST_PAUSED;
        end else if (pause_s) begin
          next_state = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!pause_s)        next_state = ST_RUN;
        else if (enter_pulse) next_state = ST_STEP;
      end
      ST_WAIT_IN: begin
        if (enter_pulse) begin
          capture_in = 1'b1;
          next_state = ST_COMMIT;
        end
      end
      ST_PRINT: begin
        if (hold_cnt == '0) begin
          commit_print = 1'b1;
          next_state   = ST_COMMIT;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      ST_COMMIT: begin
        cpu_en_c   = 1'b1;
        next_state = pause_s ? ST_PAUSED : ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= ST_RUN;
      hold_cnt     <= '0;
      in_value_q   <= '0;
      commit_is_in <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (load_cnt)     hold_cnt <= HOLD_LOAD;
      else if (dec_cnt) hold_cnt <= hold_cnt - CNT_W'(1);
      if (capture_in) begin
        in_value_q   <= 32'(sw_value);
        commit_is_in <= 1'b1;
      end else if (commit_print) begin
        commit_is_in <= 1'b0;
      end
    end
  end

  // Strobes are forced low while reset is asserted so nothing commits mid-reset.
  assign cpu_en       = cpu_en_c & ~reset;
  assign in_ack       = (cur_state == ST_COMMIT) & commit_is_in & ~reset;
  assign print_active = ((cur_state == ST_PRINT) |
                         ((cur_state == ST_COMMIT) & ~commit_is_in)) & ~reset;
  assign in_value     = in_value_q;
  assign state        = cur_state;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: per-cycle expected outputs are queued by
// the stimulus and compared by an independent negedge monitor.
module tb_run_controller;

  localparam int DATA_W = 4;
  localparam int HOLD   = 4;
  localparam int SYNC   = 2;
  localparam int VEC_W  = 38;

  localparam int R  = 0;
  localparam int P  = 1;
  localparam int S  = 2;
  localparam int W  = 3;
  localparam int PR = 4;
  localparam int C  = 5;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              pause_sw  = 1'b0;
  logic              enter     = 1'b0;
  logic              in_req    = 1'b0;
  logic              print_req = 1'b0;
  logic [DATA_W-1:0] sw_value  = '0;
  logic              cpu_en, in_ack, print_active;
  logic [31:0]       in_value;
  logic [2:0]        state;

  logic [VEC_W-1:0] exp_q[$];
  int    checks = 0;
  int    passed = 0;
  int    cyc_n  = 0;
  string phase  = "init";

  // clock/reset block
  always #5 clk = ~clk;

  run_controller #(
    .DATA_W            (DATA_W),
    .PRINT_HOLD_CYCLES (HOLD),
    .SYNC_STAGES       (SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pause_sw     (pause_sw),
    .enter        (enter),
    .in_req       (in_req),
    .print_req    (print_req),
    .sw_value     (sw_value),
    .cpu_en       (cpu_en),
    .in_value     (in_value),
    .in_ack       (in_ack),
    .print_active (print_active),
    .state        (state)
  );

  // driver: queue the expected outputs for the current cycle, then advance
  task automatic step(input int st, input logic en, input logic ack,
                      input logic pa, input logic [31:0] val);
    exp_q.push_back({3'(st), en, ack, pa, val});
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [VEC_W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, cpu_en, in_ack, print_active, in_value};
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s cycle %0d: state/cpu_en/in_ack/print_active/in_value got %0d/%b/%b/%b/%h want %0d/%b/%b/%b/%h",
                    phase, cyc_n, a[37:35], a[34], a[33], a[32], a[31:0],
                    e[37:35], e[34], e[33], e[32], e[31:0]);
      cyc_n++;
    end
  end

  initial begin
    @(posedge clk);
    #1;

    phase = "reset";
    step(R, 0, 0, 0, 0);
    step(R, 0, 0, 0, 0);
    reset = 1'b0;

    phase = "run";
    repeat (4) step(R, 1, 0, 0, 0);

    phase = "in";
    in_req = 1'b1; sw_value = 4'hA;
    step(R, 0, 0, 0, 0);
    repeat (9) step(W, 0, 0, 0, 0);
    enter = 1'b1; step(W, 0, 0, 0, 0);
    enter = 1'b0; step(W, 0, 0, 0, 0);
    step(W, 0, 0, 0, 0);
    step(C, 1, 1, 0, 32'hA);
    in_req = 1'b0; step(R, 1, 0, 0, 32'hA);

    phase = "print";
    print_req = 1'b1; step(R, 0, 0, 0, 32'hA);
    repeat (HOLD) step(PR, 0, 0, 1, 32'hA);
    step(C, 1, 0, 1, 32'hA);
    print_req = 1'b0; step(R, 1, 0, 0, 32'hA);

    phase = "pause";
    pause_sw = 1'b1;
    repeat (3) step(R, 1, 0, 0, 32'hA);
    step(P, 0, 0, 0, 32'hA);
    repeat (2) begin
      enter = 1'b1; step(P, 0, 0, 0, 32'hA);
      enter = 1'b0; step(P, 0, 0, 0, 32'hA);
      step(P, 0, 0, 0, 32'hA);
      step(S, 1, 0, 0, 32'hA);
      step(P, 0, 0, 0, 32'hA);
    end
    pause_sw = 1'b0;
    repeat (3) step(P, 0, 0, 0, 32'hA);
    step(R, 1, 0, 0, 32'hA);

    phase = "step_in";
    pause_sw = 1'b1;
    repeat (3) step(R, 1, 0, 0, 32'hA);
    step(P, 0, 0, 0, 32'hA);
    in_req = 1'b1;
    enter = 1'b1; step(P, 0, 0, 0, 32'hA);
    enter = 1'b0; step(P, 0, 0, 0, 32'hA);
    step(P, 0, 0, 0, 32'hA);
    step(S, 0, 0, 0, 32'hA);
    sw_value = 4'h5;
    step(W, 0, 0, 0, 32'hA);
    step(W, 0, 0, 0, 32'hA);
    enter = 1'b1; step(W, 0, 0, 0, 32'hA);
    enter = 1'b0; step(W, 0, 0, 0, 32'hA);
    step(W, 0, 0, 0, 32'hA);
    step(C, 1, 1, 0, 32'h5);
    in_req = 1'b0;
    step(P, 0, 0, 0, 32'h5);
    step(P, 0, 0, 0, 32'h5);

    phase = "reset_in_wait";
    pause_sw = 1'b0;
    repeat (3) step(P, 0, 0, 0, 32'h5);
    step(R, 1, 0, 0, 32'h5);
    in_req = 1'b1; sw_value = 4'hF;
    step(R, 0, 0, 0, 32'h5);
    step(W, 0, 0, 0, 32'h5);
    enter = 1'b1; step(W, 0, 0, 0, 32'h5);
    enter = 1'b0; reset = 1'b1;
    step(W, 0, 0, 0, 32'h5);
    reset = 1'b0; in_req = 1'b0;
    repeat (4) step(R, 1, 0, 0, 0);

    phase = "in_over_print";
    in_req = 1'b1; print_req = 1'b1; sw_value = 4'h3;
    step(R, 0, 0, 0, 0);
    enter = 1'b1; step(W, 0, 0, 0, 0);
    enter = 1'b0; step(W, 0, 0, 0, 0);
    step(W, 0, 0, 0, 0);
    step(C, 1, 1, 0, 32'h3);
    in_req = 1'b0; print_req = 1'b0;
    step(R, 1, 0, 0, 32'h3);
    step(R, 1, 0, 0, 32'h3);

    // final report
    @(negedge clk);
    #1;
    phase = "drain";
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: queue entries left %0d want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Sequences the single-cycle MIPS datapath on the board: generates the CPU clock enable, pauses and single-steps it, stalls on IN instructions until the user presses enter, and holds PRINT instructions so the display can show them.
- Sits between the switch/key synchroniser inputs and the datapath enable and I/O inputs. Runs on the divided clock.

Parameters:
- DATA_W, 4, width of the switch input value captured for IN.
- PRINT_HOLD_CYCLES, 4, stall cycles on PRINT before commit; must be >= 1.
- SYNC_STAGES, 2, flip-flop stages synchronising the enter and pause inputs; must be >= 2.

Ports:
- clk  in  1  divided system clock.
- reset  in  1  synchronous, active-high; clears all state on the rising edge where it is sampled high.
- pause_sw  in  1  level; 1 = pause requested (asynchronous source).
- enter  in  1  raw enter key; active-high level (asynchronous source).
- in_req  in  1  current instruction is IN (decoded by datapath).
- print_req  in  1  current instruction is PRINT.
- sw_value  in  DATA_W  switch value for IN.
- cpu_en  out  1  datapath commit enable for PC, register file and memory writes.
- in_value  out  32  zero-extended captured switch value.
- in_ack  out  1  one-cycle strobe, IN is committing with in_value.
- print_active  out  1  high while a PRINT is being held.
- state  out  3  current FSM state, for the HEX display.

Behaviour:
- pause_sw and enter each pass through a SYNC_STAGES synchroniser. enter_pulse = synchronised enter AND NOT its previous value: one cycle per press.
- State encoding: RUN=0, PAUSED=1, STEP=2, WAIT_IN=3, PRINT=4, COMMIT=5. Codes 6 and 7 go to RUN.
- Reset values:
  - state=RUN, in_value=0, hold counter=0, synchroniser flops=0.
  - cpu_en=0, in_ack=0 and print_active=0 in the reset cycle.
- cpu_en is combinational from the registered state and the current inputs:
  - In RUN and STEP: cpu_en = NOT in_req AND NOT print_req.
  - In COMMIT: cpu_en = 1.
  - In all other states: cpu_en = 0.
- in_ack = 1 only in COMMIT when that COMMIT was entered from WAIT_IN (tracked by a registered commit_is_in flag).
- print_active = 1 in PRINT and in the COMMIT that follows PRINT.
- Transitions in RUN and STEP (first matching rule wins):
  - in_req -> WAIT_IN.
  - print_req -> PRINT; load hold counter = PRINT_HOLD_CYCLES-1.
  - STEP -> PAUSED.
  - RUN with synchronised pause = 1 -> PAUSED; the instruction in that RUN cycle still commits.
  - Otherwise stay.
- PAUSED:
  - synchronised pause = 0 -> RUN.
  - else enter_pulse -> STEP.
- WAIT_IN: on enter_pulse, in_value <= zero-extended sw_value, commit_is_in <= 1, -> COMMIT. Otherwise wait indefinitely.
- PRINT: while counter != 0, decrement. At counter = 0 -> COMMIT with commit_is_in <= 0. Total stall is PRINT_HOLD_CYCLES cycles.
- COMMIT: exactly one cycle, then -> PAUSED if synchronised pause = 1, else RUN.
- pause changes during WAIT_IN, PRINT and COMMIT have no effect until the COMMIT exit decision.
- in_req and print_req both high: in_req takes priority.
- An enter_pulse that launches a STEP is consumed. WAIT_IN needs a fresh press.
- in_value holds its last captured value until the next IN capture or reset.
- reset while in WAIT_IN or PRINT: the pending instruction is abandoned and no in_ack is produced.

Decomposition:
- Shared package: the state encoding constants (RUN..COMMIT) and STATE_W=3. The display decoder uses them to show mode letters.
- One sub-module: edge_sync (SYNC_STAGES synchroniser with optional rising-edge pulse output), instantiated for enter and for pause. It is reusable for the reset switch.

Test Plan:
- Reset for 2 cycles, then in_req=print_req=0 and pause_sw=0 -> state=0, cpu_en=1 every cycle, in_ack=0, in_value=0.
- in_req=1 while in RUN, sw_value=4'hA, enter pulsed 10 cycles later:
  - cpu_en=0 and state=3 until enter is seen.
  - Then state=5 for one cycle with cpu_en=1, in_ack=1, in_value=32'h0000000A.
  - Then RUN.
- print_req=1 with PRINT_HOLD_CYCLES=4 -> exactly 4 cycles of state=4, then 1 cycle of COMMIT with cpu_en=1 and print_active=1, then RUN. in_ack stays 0.
- pause_sw=1 -> PAUSED after the synchroniser latency. Each enter press gives exactly one cpu_en=1 cycle (state 2). Release pause -> RUN.
- Paused step onto an IN instruction -> STEP, then WAIT_IN. The first press after that captures sw_value. COMMIT then returns to PAUSED because pause is still 1.
- reset asserted in WAIT_IN -> next cycle state=0, in_ack never pulses, in_value=0.
